// File: rtl/neuro_cfg_sequencer.sv
// neuro_cfg_sequencer: loads config bytes from the pin logic into the cell array's serial config
// chain (MSB first), commits them with a latch pulse, then emits periodic neuron update ticks.
// Optional feature macro: CFG_READBACK_EN (captures the chain tail while shifting and returns
// the previous chain contents one byte per 8-shift group).
module neuro_cfg_sequencer #(
  parameter int unsigned NUM_CELLS = 8,
  parameter int unsigned CFG_BITS  = 8,
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_start,
  input  logic [7:0] byte_in,
  input  logic       byte_strobe,
  output logic       byte_ack,
  output logic       cfg_shift_en,
  output logic       cfg_sdata,
  input  logic       cfg_sret,
  output logic       cfg_latch,
  output logic       tick,
  output logic       busy,
  output logic       loaded,
  output logic       err_overrun,
  output logic [7:0] rb_byte,
  output logic       rb_valid
);

  localparam int unsigned NBYTES = (NUM_CELLS * CFG_BITS) / 8;
  localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LastByte = BCW'(NBYTES - 1);
  localparam logic [23:0]    TickLast = MAX_COUNT - 24'd1;

  typedef enum logic [2:0] {StIdle, StWaitByte, StShift, StLatch, StRun} state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     sh_q, sh_d;
  logic [23:0]    tick_cnt_q, tick_cnt_d;
  logic           byte_ack_q, byte_ack_d;
  logic           shift_en_q, shift_en_d;
  logic           sdata_q, sdata_d;
  logic           latch_q, latch_d;
  logic           tick_q, tick_d;
  logic           busy_q, busy_d;
  logic           loaded_q, loaded_d;
  logic           err_q, err_d;

  // Next-state and registered-output decode; cfg_start overrides everything else.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    tick_cnt_d = tick_cnt_q;
    byte_ack_d = 1'b0;
    shift_en_d = 1'b0;
    sdata_d    = 1'b0;
    latch_d    = 1'b0;
    tick_d     = 1'b0;
    loaded_d   = loaded_q;
    err_d      = err_q;
    if (cfg_start) begin
      // A strobe in the same cycle is silently dropped.
      state_d    = StWaitByte;
      byte_cnt_d = '0;
      bit_cnt_d  = 3'd0;
      tick_cnt_d = 24'd0;
      loaded_d   = 1'b0;
      err_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (byte_strobe) err_d = 1'b1;
        end
        StWaitByte: begin
          if (byte_strobe) begin
            state_d    = StShift;
            sh_d       = {byte_in[6:0], 1'b0};
            bit_cnt_d  = 3'd0;
            shift_en_d = 1'b1;
            sdata_d    = byte_in[7];
            byte_ack_d = 1'b1;
          end
        end
        StShift: begin
          if (byte_strobe) err_d = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q == LastByte) begin
              state_d  = StLatch;
              latch_d  = 1'b1;
              loaded_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
              state_d    = StWaitByte;
            end
          end else begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            shift_en_d = 1'b1;
            sdata_d    = sh_q[7];
            sh_d       = {sh_q[6:0], 1'b0};
          end
        end
        StLatch: begin
          if (byte_strobe) err_d = 1'b1;
          state_d    = StRun;
          tick_cnt_d = 24'd0;
          tick_d     = (TickLast == 24'd0);
        end
        StRun: begin
          if (byte_strobe) err_d = 1'b1;
          tick_cnt_d = (tick_cnt_q == TickLast) ? 24'd0 : tick_cnt_q + 24'd1;
          tick_d     = (tick_cnt_d == TickLast);
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d == StWaitByte) || (state_d == StShift) || (state_d == StLatch);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      sh_q       <= 8'h00;
      tick_cnt_q <= 24'd0;
      byte_ack_q <= 1'b0;
      shift_en_q <= 1'b0;
      sdata_q    <= 1'b0;
      latch_q    <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      tick_cnt_q <= tick_cnt_d;
      byte_ack_q <= byte_ack_d;
      shift_en_q <= shift_en_d;
      sdata_q    <= sdata_d;
      latch_q    <= latch_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
    end
  end

  assign byte_ack     = byte_ack_q;
  assign cfg_shift_en = shift_en_q;
  assign cfg_sdata    = sdata_q;
  assign cfg_latch    = latch_q;
  assign tick         = tick_q;
  assign busy         = busy_q;
  assign loaded       = loaded_q;
  assign err_overrun  = err_q;

`ifdef CFG_READBACK_EN
  logic [7:0] rb_sh_q, rb_sh_d;
  logic [7:0] rb_byte_q, rb_byte_d;
  logic       rb_valid_q, rb_valid_d;

  // Sample the chain tail on each shift; publish after the 8th shift of an uninterrupted group.
  always_comb begin
    rb_sh_d    = rb_sh_q;
    rb_byte_d  = rb_byte_q;
    rb_valid_d = 1'b0;
    if (shift_en_q) rb_sh_d = {rb_sh_q[6:0], cfg_sret};
    if (shift_en_q && (bit_cnt_q == 3'd7) && !cfg_start) begin
      rb_byte_d  = rb_sh_d;
      rb_valid_d = 1'b1;
    end
  end

  // Readback registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_sh_q    <= 8'h00;
      rb_byte_q  <= 8'h00;
      rb_valid_q <= 1'b0;
    end else begin
      rb_sh_q    <= rb_sh_d;
      rb_byte_q  <= rb_byte_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_byte  = rb_byte_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_sret;
  assign unused_sret = cfg_sret;
  assign rb_byte     = 8'h00;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_neuro_cfg_sequencer.sv
// Scoreboard bench for neuro_cfg_sequencer: the driver predicts timestamped events and level
// changes from the behavioural rules; a negedge monitor pops and compares them.
module tb_neuro_cfg_sequencer;

  localparam int NB = 2;  // 2 cells x 8 bits
  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_start = 1'b0;
  logic       byte_strobe = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       cfg_sret;
  logic       byte_ack, cfg_shift_en, cfg_sdata, cfg_latch, tick, busy, loaded, err_overrun;
  logic [7:0] rb_byte;
  logic       rb_valid;
  logic       tick1;
  logic       unused1_ack, unused1_sen, unused1_sd, unused1_lat, unused1_busy, unused1_ld;
  logic       unused1_err, unused1_rbv;
  logic [7:0] unused1_rb;

  neuro_cfg_sequencer #(.NUM_CELLS(2), .CFG_BITS(8), .MAX_COUNT(24'd4)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .byte_in(byte_in),
    .byte_strobe(byte_strobe), .byte_ack(byte_ack), .cfg_shift_en(cfg_shift_en),
    .cfg_sdata(cfg_sdata), .cfg_sret(cfg_sret), .cfg_latch(cfg_latch), .tick(tick),
    .busy(busy), .loaded(loaded), .err_overrun(err_overrun), .rb_byte(rb_byte),
    .rb_valid(rb_valid)
  );

  neuro_cfg_sequencer #(.NUM_CELLS(2), .CFG_BITS(8), .MAX_COUNT(24'd1)) dut1 (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .byte_in(byte_in),
    .byte_strobe(byte_strobe), .byte_ack(unused1_ack), .cfg_shift_en(unused1_sen),
    .cfg_sdata(unused1_sd), .cfg_sret(cfg_sret), .cfg_latch(unused1_lat), .tick(tick1),
    .busy(unused1_busy), .loaded(unused1_ld), .err_overrun(unused1_err), .rb_byte(unused1_rb),
    .rb_valid(unused1_rbv)
  );

  always #5 clk = ~clk;

  // Physical 16-bit cell chain, preloaded with the previous commit.
  logic [15:0] chain = 16'hBEEF;
  always @(posedge clk) if (cfg_shift_en) chain <= {chain[14:0], cfg_sdata};
  assign cfg_sret = chain[15];

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } evt_t;

  localparam int KAck = 0, KBit = 1, KLat = 2, KTick = 3, KRb = 4;
  localparam int LBusy = 0, LLoad = 1, LErr = 2, LTick1 = 3;

  evt_t eq[5][$];
  evt_t lq[4][$];
  logic lcur[4];
  logic chain_ref[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   nacc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ename(int k);
    case (k)
      KAck:    return "byte_ack";
      KBit:    return "cfg_sdata";
      KLat:    return "cfg_latch";
      KTick:   return "tick";
      default: return "rb_byte";
    endcase
  endfunction

  function automatic string lname(int k);
    case (k)
      LBusy:   return "busy";
      LLoad:   return "loaded";
      LErr:    return "err_overrun";
      default: return "tick_max1";
    endcase
  endfunction

  function void push_evt(int k, int c, logic [7:0] v);
    evt_t e;
    e.cyc = c;
    e.val = v;
    eq[k].push_back(e);
  endfunction

  function void push_lvl(int k, int c, logic v);
    evt_t e;
    e.cyc = c;
    e.val = {7'b0, v};
    lq[k].push_back(e);
  endfunction

  function void check_evt(int k, logic fired, logic [7:0] got);
    while (eq[k].size() > 0 && eq[k][0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL %s missing: got no event, required one at cycle %0d", ename(k),
               eq[k][0].cyc);
      eq[k].delete(0);
    end
    if (fired) begin
      total++;
      if (eq[k].size() == 0 || eq[k][0].cyc != cyc) begin
        bad++;
        $display("FAIL %s unexpected: got event at cycle %0d, required none", ename(k), cyc);
      end else begin
        if (got !== eq[k][0].val) begin
          bad++;
          $display("FAIL %s value at cycle %0d: got %h required %h", ename(k), cyc, got,
                   eq[k][0].val);
        end
        eq[k].delete(0);
      end
    end
  endfunction

  function void check_lvl(int k, logic got);
    while (lq[k].size() > 0 && lq[k][0].cyc <= cyc) begin
      lcur[k] = lq[k][0].val[0];
      lq[k].delete(0);
    end
    total++;
    if (got !== lcur[k]) begin
      bad++;
      $display("FAIL %s level at cycle %0d: got %b required %b", lname(k), cyc, got, lcur[k]);
    end
  endfunction

  function void chk(string nm, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endfunction

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check_evt(KAck, byte_ack, 8'h00);
      check_evt(KBit, cfg_shift_en, {7'b0, cfg_sdata});
      check_evt(KLat, cfg_latch, 8'h00);
      check_evt(KTick, tick, 8'h00);
`ifdef CFG_READBACK_EN
      check_evt(KRb, rb_valid, rb_byte);
`else
      chk("rb_idle", {rb_valid, rb_byte[6:0]} | {7'b0, rb_byte[7]}, 8'h00);
`endif
      check_lvl(LBusy, busy);
      check_lvl(LLoad, loaded);
      check_lvl(LErr, err_overrun);
      check_lvl(LTick1, tick1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cfg_start   = 1'b0;
    byte_strobe = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_ack"}, {7'b0, byte_ack}, 8'h00);
    chk({tag, "_shift_en"}, {7'b0, cfg_shift_en}, 8'h00);
    chk({tag, "_sdata"}, {7'b0, cfg_sdata}, 8'h00);
    chk({tag, "_latch"}, {7'b0, cfg_latch}, 8'h00);
    chk({tag, "_tick"}, {7'b0, tick}, 8'h00);
    chk({tag, "_busy"}, {7'b0, busy}, 8'h00);
    chk({tag, "_loaded"}, {7'b0, loaded}, 8'h00);
    chk({tag, "_err"}, {7'b0, err_overrun}, 8'h00);
    chk({tag, "_rb_byte"}, rb_byte, 8'h00);
    chk({tag, "_rb_valid"}, {7'b0, rb_valid}, 8'h00);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_all_zero("rst_async");
    for (int k = 0; k < 5; k++) eq[k].delete();
    for (int k = 0; k < 4; k++) begin
      lq[k].delete();
      lcur[k] = 1'b0;
    end
    nacc = 0;
    step();
    check_all_zero("rst_edge");
    step();
    reset = 1'b0;
    step();
    mon_en = 1'b1;
  endtask

  task automatic do_start(input bit with_strobe);
    cfg_start = 1'b1;
    if (with_strobe) begin
      byte_strobe = 1'b1;
      byte_in     = 8'($urandom);
    end
    push_lvl(LBusy, cyc + 1, 1'b1);
    push_lvl(LLoad, cyc + 1, 1'b0);
    push_lvl(LErr, cyc + 1, 1'b0);
    push_lvl(LTick1, cyc + 1, 1'b0);
    nacc = 0;
    step();
  endtask

  // Offers one byte in WAIT_BYTE. abort_at=k (1..7) interrupts in shift cycle k via cfg_start
  // or, with abort_rst, via reset; poke strobes again during the third shift cycle.
  task automatic send_byte(input logic [7:0] b, input int abort_at, input bit abort_rst,
                           input bit poke);
    int         c0;
    int         nb;
    logic [7:0] rbv;
    rbv = 8'h00;
    repeat ($urandom_range(0, 2)) step();
    c0          = cyc;
    byte_strobe = 1'b1;
    byte_in     = b;
    push_evt(KAck, c0 + 1, 8'h00);
    nb = (abort_at == 0) ? 8 : (abort_rst ? abort_at - 1 : abort_at);
    for (int k = 0; k < nb; k++) begin
      push_evt(KBit, c0 + 1 + k, {7'b0, b[7-k]});
      rbv = {rbv[6:0], chain_ref.pop_front()};
      chain_ref.push_back(b[7-k]);
    end
    if (abort_at == 0) begin
`ifdef CFG_READBACK_EN
      push_evt(KRb, c0 + 9, rbv);
`endif
      nacc++;
      if (nacc == NB) begin
        push_evt(KLat, c0 + 9, 8'h00);
        push_lvl(LLoad, c0 + 9, 1'b1);
        push_lvl(LBusy, c0 + 10, 1'b0);
        push_lvl(LTick1, c0 + 10, 1'b1);
      end
    end
    step();
    for (int k = 1; k <= 8; k++) begin
      if (abort_at == k) begin
        if (abort_rst) do_reset();
        else do_start(1'b0);
        return;
      end
      if (poke && k == 3) begin
        byte_strobe = 1'b1;
        byte_in     = 8'($urandom);
        push_lvl(LErr, cyc + 1, 1'b1);
      end
      step();
    end
  endtask

  // Called in the latch cycle; stays n cycles (latch + RUN), optionally strobing once.
  task automatic run_phase(input int n, input bit poke);
    int l;
    int pk;
    l  = cyc;
    pk = $urandom_range(0, n - 1);
    for (int k = 1; MC * k <= n; k++) push_evt(KTick, l + MC * k, 8'h00);
    for (int i = 0; i < n; i++) begin
      if (poke && i == pk) begin
        byte_strobe = 1'b1;
        byte_in     = 8'($urandom);
        push_lvl(LErr, cyc + 1, 1'b1);
      end
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] init;
    int          a;
    bit          r;
    int          i;
    init = 16'hBEEF;
    for (int k = 15; k >= 0; k--) chain_ref.push_back(init[k]);
    for (int k = 0; k < 4; k++) lcur[k] = 1'b0;

    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();
    mon_en = 1'b1;

    // Strobe while idle flags overrun; cfg_start clears it.
    byte_strobe = 1'b1;
    byte_in     = 8'h11;
    push_lvl(LErr, cyc + 1, 1'b1);
    step();
    step();
    do_start(1'b0);

    // Directed load A5, 3C; ticks every 4 cycles after the latch; readback BE, EF.
    send_byte(8'hA5, 0, 1'b0, 1'b0);
    send_byte(8'h3C, 0, 1'b0, 1'b0);
    run_phase(13, 1'b0);
    do_start(1'b0);

    // Overrun during shift of byte 0, then restart from RUN together with a strobe.
    send_byte(8'h5A, 0, 1'b0, 1'b1);
    send_byte(8'hC3, 0, 1'b0, 1'b0);
    run_phase(6, 1'b1);
    do_start(1'b1);

    // Load abandoned mid-shift, then a complete one.
    send_byte(8'hF0, 4, 1'b0, 1'b0);
    send_byte(8'h0F, 0, 1'b0, 1'b0);
    send_byte(8'h99, 0, 1'b0, 1'b0);
    run_phase(3, 1'b0);
    do_start(1'b0);

    // Reset in the middle of a shift group.
    send_byte(8'h77, 3, 1'b1, 1'b0);
    do_start(1'b0);

    // Randomised episodes.
    repeat (25) begin
      i = 0;
      while (i < NB) begin
        a = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
        r = (a != 0) && ($urandom_range(0, 3) == 0);
        send_byte(8'($urandom), a, r, ($urandom_range(0, 3) == 0));
        if (a != 0) begin
          if (r) do_start(1'b0);
          i = 0;
        end else begin
          i++;
        end
      end
      run_phase($urandom_range(1, 12), $urandom_range(0, 1) == 1);
      do_start($urandom_range(0, 1) == 1);
    end

    repeat (3) step();
    mon_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (eq[k].size() != 0) begin
        bad++;
        $display("FAIL %s leftover: got %0d pending, required 0", ename(k), eq[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
